// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch/decode handshake bundle for inst_fetch_queue; stats ports present when IFQ_STATS_EN is defined.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 64,
  parameter int INST_W = 32
);
  localparam int PTR_W = $clog2(DEPTH);
  logic flush;
  logic enq_valid;
  logic enq_ready;
  logic [0:1] enq_mask;
  logic [0:2*INST_W-1] enq_data;
  logic [0:1] deq_valid;
  logic [0:INST_W-1] deq_data0;
  logic [0:INST_W-1] deq_data1;
  logic [0:1] deq_take;
  logic [0:PTR_W] count;
`ifdef IFQ_STATS_EN
  logic [0:PTR_W] hwm;
  logic [0:31] stall_cnt;
`endif
  modport master (
    output flush, enq_valid, enq_mask, enq_data, deq_take,
    input enq_ready, deq_valid, deq_data0, deq_data1, count
`ifdef IFQ_STATS_EN
    , input hwm, stall_cnt
`endif
  );
  modport slave (
    input flush, enq_valid, enq_mask, enq_data, deq_take,
    output enq_ready, deq_valid, deq_data0, deq_data1, count
`ifdef IFQ_STATS_EN
    , output hwm, stall_cnt
`endif
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular dual-slot instruction queue between fetch and dual-issue decode.
// IFQ_STATS_EN adds a high-water mark and a saturating enqueue-stall counter.
module inst_fetch_queue #(
  parameter int DEPTH = 64,
  parameter int INST_W = 32
) (
  input logic clk,
  input logic rst,
  inst_fetch_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0] head_q, head_d, tail_q, tail_d, count, take_req, take, enq_n;
  logic [PTR_W-1:0] h0, h1, t0, t1;
  logic [INST_W-1:0] slot0, slot1, wr0_data;
  logic enq_fire;
  assign count = tail_q - head_q;
  assign h0 = head_q[PTR_W-1:0];
  assign h1 = h0 + 1'b1;
  assign t0 = tail_q[PTR_W-1:0];
  assign t1 = t0 + 1'b1;
  assign slot0 = q.enq_data[0:INST_W-1];
  assign slot1 = q.enq_data[INST_W:2*INST_W-1];
  assign q.count = count;
  assign q.enq_ready = count <= (PTR_W+1)'(DEPTH - 2);
  assign q.deq_valid = {count != '0, count >= (PTR_W+1)'(2)};
  assign q.deq_data0 = q.deq_valid[0] ? mem_q[h0] : '0;
  assign q.deq_data1 = q.deq_valid[1] ? mem_q[h1] : '0;
  always_comb begin
    enq_fire = q.enq_valid & q.enq_ready & |q.enq_mask;
    enq_n = !enq_fire ? '0 : &q.enq_mask ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    // take is clamped against pre-edge occupancy so fresh entries are never consumed
    take_req = q.deq_take[0] ? (PTR_W+1)'(2) : (PTR_W+1)'(q.deq_take[1]);
    take = take_req > count ? count : take_req;
    head_d = q.flush ? '0 : head_q + take;
    tail_d = q.flush ? '0 : tail_q + enq_n;
    wr0_data = q.enq_mask[0] ? slot0 : slot1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !q.flush && enq_fire) begin
      mem_q[t0] <= wr0_data;
      if (&q.enq_mask) mem_q[t1] <= slot1;
    end
  end
`ifdef IFQ_STATS_EN
  logic [PTR_W:0] hwm_q, hwm_d, count_d;
  logic [31:0] stall_q, stall_d;
  always_comb begin
    count_d = tail_d - head_d;
    hwm_d = count_d > hwm_q ? count_d : hwm_q;
    stall_d = (q.enq_valid & ~q.enq_ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
      stall_q <= '0;
    end else begin
      hwm_q <= hwm_d;
      stall_q <= stall_d;
    end
  end
  assign q.hwm = hwm_q;
  assign q.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized bench for inst_fetch_queue (DEPTH=8) against a queue-based model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int W = 32;
  localparam logic [W-1:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C, D = 32'hD000_000D;
  localparam logic [W-1:0] E = 32'hE000_000E, F = 32'hF000_000F, G = 32'h6000_0006, H = 32'h7000_0007;
  localparam logic [W-1:0] X = 32'hDEAD_0001, Y = 32'hDEAD_0002;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  inst_fetch_queue_if #(.DEPTH(DEPTH), .INST_W(W)) ifq ();
  inst_fetch_queue #(.DEPTH(DEPTH), .INST_W(W)) dut (.clk(clk), .rst(rst), .q(ifq.slave));
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] mdl[$];
  int hwm_m = 0;
  longint stall_m = 0;
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic check();
    int n;
    logic [W-1:0] e0, e1;
    n = mdl.size();
    e0 = '0;
    e1 = '0;
    if (n >= 1) e0 = mdl[0];
    if (n >= 2) e1 = mdl[1];
    cmp("count", 64'(ifq.count), 64'(n));
    cmp("enq_ready", 64'(ifq.enq_ready), 64'((DEPTH - n) >= 2));
    cmp("deq_valid", 64'(ifq.deq_valid), 64'({n >= 1, n >= 2}));
    cmp("deq_data0", 64'(ifq.deq_data0), 64'(e0));
    cmp("deq_data1", 64'(ifq.deq_data1), 64'(e1));
`ifdef IFQ_STATS_EN
    cmp("hwm", 64'(ifq.hwm), 64'(hwm_m));
    cmp("stall_cnt", 64'(ifq.stall_cnt), 64'(stall_m));
`endif
  endtask
  task automatic cyc(input logic r, input logic f, input logic ev, input logic [0:1] m,
                     input logic [0:2*W-1] d, input logic [0:1] tk);
    int n, t;
    check();
    rst = r;
    ifq.flush = f;
    ifq.enq_valid = ev;
    ifq.enq_mask = m;
    ifq.enq_data = d;
    ifq.deq_take = tk;
    @(posedge clk);
    n = mdl.size();
    if (r) begin
      mdl.delete();
      hwm_m = 0;
      stall_m = 0;
    end else begin
      if (ev && (DEPTH - n) < 2 && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (f) mdl.delete();
      else begin
        t = (tk > 2) ? 2 : int'(tk);
        if (t > n) t = n;
        repeat (t) void'(mdl.pop_front());
        if (ev && (DEPTH - n) >= 2) begin
          if (m[0]) mdl.push_back(d[0:W-1]);
          if (m[1]) mdl.push_back(d[W:2*W-1]);
        end
      end
      if (mdl.size() > hwm_m) hwm_m = mdl.size();
    end
    @(negedge clk);
  endtask
  initial begin
    logic r, f, ev;
    logic [0:1] m, tk;
    logic [0:2*W-1] d;
    rst = 1;
    ifq.flush = 0;
    ifq.enq_valid = 0;
    ifq.enq_mask = 2'b00;
    ifq.enq_data = '0;
    ifq.deq_take = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    cmp("rst_count", 64'(ifq.count), 64'd0);
    cmp("rst_enq_ready", 64'(ifq.enq_ready), 64'd1);
    cmp("rst_deq_valid", 64'(ifq.deq_valid), 64'd0);
    cmp("rst_deq_data0", 64'(ifq.deq_data0), 64'd0);
    cyc(0, 0, 1, 2'b11, {A, B}, 2'b00);
    cmp("t1_count", 64'(ifq.count), 64'd2);
    cmp("t1_deq_valid", 64'(ifq.deq_valid), 64'd3);
    cmp("t1_data0", 64'(ifq.deq_data0), 64'(A));
    cmp("t1_data1", 64'(ifq.deq_data1), 64'(B));
    cyc(0, 1, 1, 2'b11, {E, F}, 2'b11);
    cmp("flush_count", 64'(ifq.count), 64'd0);
    cyc(0, 0, 1, 2'b01, {X, C}, 2'b00);
    cyc(0, 0, 1, 2'b10, {D, Y}, 2'b00);
    cmp("t2_count", 64'(ifq.count), 64'd2);
    cmp("t2_data0", 64'(ifq.deq_data0), 64'(C));
    cmp("t2_data1", 64'(ifq.deq_data1), 64'(D));
    cyc(0, 0, 1, 2'b11, {32'h11, 32'h12}, 2'b00);
    cyc(0, 0, 1, 2'b11, {32'h13, 32'h14}, 2'b00);
    cyc(0, 0, 1, 2'b10, {32'h15, Y}, 2'b00);
    cmp("t3_enq_ready", 64'(ifq.enq_ready), 64'd0);
    cyc(0, 0, 1, 2'b11, {E, F}, 2'b00);
    cmp("t3_count", 64'(ifq.count), 64'd7);
    cmp("t3_data0", 64'(ifq.deq_data0), 64'(C));
    cyc(0, 0, 0, 2'b00, '0, 2'b01);
    for (int k = 0; k < 10; k++)
      cyc(0, 0, 1, 2'b11, {W'(200 + 2 * k), W'(201 + 2 * k)}, 2'b10);
    cmp("t4_count", 64'(ifq.count), 64'd6);
    cyc(0, 0, 0, 2'b00, '0, 2'b10);
    cyc(0, 0, 0, 2'b00, '0, 2'b10);
    cyc(0, 0, 0, 2'b00, '0, 2'b01);
    cmp("t5_pre_count", 64'(ifq.count), 64'd1);
    cyc(0, 0, 1, 2'b11, {G, H}, 2'b10);
    cmp("t5_count", 64'(ifq.count), 64'd2);
    cmp("t5_data0", 64'(ifq.deq_data0), 64'(G));
    cmp("t5_data1", 64'(ifq.deq_data1), 64'(H));
    cyc(0, 0, 1, 2'b11, {A, B}, 2'b00);
    cyc(0, 0, 1, 2'b10, {C, Y}, 2'b00);
    cmp("t6_pre_count", 64'(ifq.count), 64'd5);
    cyc(0, 1, 1, 2'b11, {E, F}, 2'b00);
    cmp("t6_count", 64'(ifq.count), 64'd0);
    cmp("t6_deq_valid", 64'(ifq.deq_valid), 64'd0);
    cmp("t6_enq_ready", 64'(ifq.enq_ready), 64'd1);
`ifdef IFQ_STATS_EN
    cmp("t6_hwm", 64'(ifq.hwm), 64'd7);
    cmp("t3_stall", 64'(ifq.stall_cnt), 64'd1);
`endif
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 3) != 0);
      m = 2'($urandom);
      tk = ((i / 200) % 2 == 1) ? 2'($urandom) : (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      d = {$urandom, $urandom};
      cyc(r, f, ev, m, d, tk);
    end
    check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
